// File: rtl/arb_pkg.sv
// Shared types and sizes for the 4-way round-robin write-port arbiter.
package arb_pkg;
   typedef enum logic {IDLE, GRANT} arb_state_t;
   localparam int REQ_N = 4;
   localparam int SEL_W = 2;
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotating-priority picker: first requester at or after ptr, wrapping mod 4.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [REQ_N-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             valid,
   output logic [SEL_W-1:0] idx
);
   logic [2*REQ_N-1:0] w_dbl;
   logic [REQ_N-1:0]   w_rot;
   logic [SEL_W-1:0]   w_off;

   // w_rot[k] is the request of index (ptr+k) mod 4, so bit 0 has top priority
   assign w_dbl = {req, req};
   assign w_rot = w_dbl[ptr +: REQ_N];

   always_comb begin
      w_off = '0;
      casez (w_rot)
         4'b???1: w_off = 2'd0;
         4'b??10: w_off = 2'd1;
         4'b?100: w_off = 2'd2;
         4'b1000: w_off = 2'd3;
         default: w_off = 2'd0;
      endcase
   end

   assign valid = |req;
   assign idx   = ptr + w_off;
endmodule

// File: rtl/rr_port_arbiter4.sv
// Round-robin arbiter for one shared write port, driving a 1-to-4 demux (ena/sel) and a one-hot gnt.
// Define ARB_STATS_EN to add the per-requester saturating grant counters on grant_cnt.
module rr_port_arbiter4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int CNT_W    = 16
)(
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [REQ_N-1:0]       req,
   input  logic [REQ_N-1:0]       done,
   output logic [REQ_N-1:0]       gnt,
   output logic                   ena,
   output logic [SEL_W-1:0]       sel
`ifdef ARB_STATS_EN
   ,output logic [REQ_N*CNT_W-1:0] grant_cnt
`endif
);
   localparam int HC_W = $clog2(MAX_HOLD) + 1;
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

   arb_state_t       r_state, w_state_next;
   logic [SEL_W-1:0] r_owner, w_owner_next;
   logic [SEL_W-1:0] r_ptr, w_ptr_next;
   logic [HC_W-1:0]  r_hold_cnt, w_hold_next;
   logic [REQ_N-1:0] r_gnt, w_gnt_next;
   logic             r_ena, w_ena_next;
   logic [SEL_W-1:0] r_sel, w_sel_next;

   logic [REQ_N-1:0] w_owner_oh;
   logic             w_owner_quit;
   logic             w_release;
   logic [SEL_W-1:0] w_pick_ptr;
   logic [REQ_N-1:0] w_pick_req;
   logic             w_pick_valid;
   logic [SEL_W-1:0] w_pick_idx;

   assign w_owner_oh   = REQ_N'(1) << r_owner;
   assign w_owner_quit = (|(done & w_owner_oh)) | ~(|(req & w_owner_oh));
   assign w_release    = (r_state == GRANT) && (w_owner_quit || (r_hold_cnt == HOLD_LAST));

   // After a release the departing owner becomes lowest priority; a timed-out owner still competes
   assign w_pick_ptr = (r_state == GRANT) ? r_owner + SEL_W'(1) : r_ptr;
   assign w_pick_req = ((r_state == GRANT) && w_owner_quit) ? (req & ~w_owner_oh) : req;

   rr_pick4 u_pick (
      .req   (w_pick_req),
      .ptr   (w_pick_ptr),
      .valid (w_pick_valid),
      .idx   (w_pick_idx)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_owner    <= '0;
         r_ptr      <= '0;
         r_hold_cnt <= '0;
         r_gnt      <= '0;
         r_ena      <= 1'b0;
         r_sel      <= '0;
      end else begin
         r_state    <= w_state_next;
         r_owner    <= w_owner_next;
         r_ptr      <= w_ptr_next;
         r_hold_cnt <= w_hold_next;
         r_gnt      <= w_gnt_next;
         r_ena      <= w_ena_next;
         r_sel      <= w_sel_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_owner_next = r_owner;
      w_ptr_next   = r_ptr;
      w_hold_next  = r_hold_cnt;
      case (r_state)
         IDLE: begin
            if (w_pick_valid) begin
               w_state_next = GRANT;
               w_owner_next = w_pick_idx;
               w_hold_next  = '0;
            end
         end
         GRANT: begin
            if (w_release) begin
               w_ptr_next  = w_pick_ptr;
               w_hold_next = '0;
               if (w_pick_valid) begin
                  w_owner_next = w_pick_idx;
               end else begin
                  w_state_next = IDLE;
               end
            end else begin
               w_hold_next = r_hold_cnt + HC_W'(1);
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so gnt/ena/sel change exactly on the grant edge
   always_comb begin
      w_gnt_next = '0;
      w_ena_next = 1'b0;
      w_sel_next = '0;
      if (w_state_next == GRANT) begin
         w_gnt_next = REQ_N'(1) << w_owner_next;
         w_ena_next = 1'b1;
         w_sel_next = w_owner_next;
      end
   end

   assign gnt = r_gnt;
   assign ena = r_ena;
   assign sel = r_sel;

`ifdef ARB_STATS_EN
   logic w_start;
   assign w_start = (w_state_next == GRANT) && ((r_state == IDLE) || w_release);

   generate
      for (genvar gi = 0; gi < REQ_N; gi++) begin : g_cnt
         logic [CNT_W-1:0] r_cnt;
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               r_cnt <= '0;
            end else if (w_start && (w_owner_next == SEL_W'(gi)) && (r_cnt != {CNT_W{1'b1}})) begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end
         assign grant_cnt[gi*CNT_W +: CNT_W] = r_cnt;
      end
   endgenerate
`endif
endmodule

// File: tb/tb_rr_port_arbiter4.sv
// Scoreboard bench for rr_port_arbiter4: a queue-based reference model predicts every cycle's grant.
// Compile with ARB_STATS_EN defined to also check grant_cnt.
module tb_rr_port_arbiter4;
   localparam int MAX_HOLD = 4;
   localparam int CNT_W    = 16;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [3:0]   req = '0;
   logic [3:0]   done = '0;
   logic [3:0]   gnt;
   logic         ena;
   logic [1:0]   sel;
`ifdef ARB_STATS_EN
   logic [4*CNT_W-1:0] grant_cnt;
`endif

   rr_port_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .ena       (ena),
      .sel       (sel)
`ifdef ARB_STATS_EN
      ,.grant_cnt (grant_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]         gnt;
      logic [1:0]         sel;
      logic               ena;
      logic [4*CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: who owns the port, who is first in line, and how long the owner has held it
   int          m_owner = -1;
   int          m_ptr = 0;
   int          m_held = 0;
   int unsigned m_cnt[4] = '{0, 0, 0, 0};

   task automatic model_step(input logic rn, input logic [3:0] rq, input logic [3:0] dn);
      logic [3:0] pool;
      bit         pick_now;
      int         cand;
      exp_t       e;
      pool = rq;
      pick_now = 0;
      if (!rn) begin
         m_owner = -1;
         m_ptr = 0;
         m_held = 0;
         for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      end else begin
         if (m_owner < 0) begin
            pick_now = 1;
         end else begin
            m_held++;
            if (dn[m_owner] || !rq[m_owner] || m_held >= MAX_HOLD) begin
               if (dn[m_owner] || !rq[m_owner]) pool[m_owner] = 1'b0;
               m_ptr = (m_owner + 1) % 4;
               m_owner = -1;
               pick_now = 1;
            end
         end
         if (pick_now) begin
            for (int k = 0; k < 4; k++) begin
               cand = (m_ptr + k) % 4;
               if (pool[cand]) begin
                  m_owner = cand;
                  m_held = 0;
                  if (m_cnt[cand] < (2**CNT_W) - 1) m_cnt[cand]++;
                  break;
               end
            end
         end
      end
      e.gnt = (m_owner >= 0) ? (4'd1 << m_owner) : 4'd0;
      e.sel = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      e.ena = (m_owner >= 0);
      for (int i = 0; i < 4; i++) e.cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      sb.push_back(e);
   endtask

   // Monitor: one expected entry per clock edge, compared half a cycle later
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_cmp++;
         if (gnt !== e.gnt || sel !== e.sel || ena !== e.ena) begin
            n_bad++;
            $display("FAIL outputs t=%0t gnt=%b sel=%0d ena=%b required gnt=%b sel=%0d ena=%b",
                     $time, gnt, sel, ena, e.gnt, e.sel, e.ena);
         end
`ifdef ARB_STATS_EN
         n_cmp++;
         if (grant_cnt !== e.cnt) begin
            n_bad++;
            $display("FAIL grant_cnt t=%0t got=%h required=%h", $time, grant_cnt, e.cnt);
         end
`endif
      end
   end

   task automatic cyc(input logic rn, input logic [3:0] rq, input logic [3:0] dn);
      reset_n = rn;
      req = rq;
      done = dn;
      @(posedge clk);
      model_step(rn, rq, dn);
      #1;
      $display("txn t=%0t reset_n=%b req=%b done=%b -> gnt=%b sel=%0d ena=%b", $time, rn, rq, dn, gnt, sel, ena);
   endtask

   // Direct check of a value fixed by hand from the arbitration rules
   task automatic chk_gnt(input string name, input logic [3:0] exp_g);
      n_cmp++;
      if (gnt !== exp_g) begin
         n_bad++;
         $display("FAIL %s gnt=%b required=%b", name, gnt, exp_g);
      end
   endtask

   logic [3:0] r_rq;

   initial begin
      // Reset with everyone requesting
      cyc(1'b0, 4'hF, 4'h0); chk_gnt("reset0", 4'b0000);
      cyc(1'b0, 4'hF, 4'h0); chk_gnt("reset1", 4'b0000);
      cyc(1'b1, 4'hF, 4'h0); chk_gnt("first_grant", 4'b0001);

      // Rotation: owner signals done every cycle
      cyc(1'b1, 4'hF, 4'hF); chk_gnt("rot1", 4'b0010);
      cyc(1'b1, 4'hF, 4'hF); chk_gnt("rot2", 4'b0100);
      cyc(1'b1, 4'hF, 4'hF); chk_gnt("rot3", 4'b1000);
      cyc(1'b1, 4'hF, 4'hF); chk_gnt("rot4", 4'b0001);

      // Timeout alternation between 0 and 2
      cyc(1'b0, 4'h0, 4'h0);
      for (int c = 0; c < 12; c++) begin
         cyc(1'b1, 4'b0101, 4'h0);
         chk_gnt("timeout", ((c / 4) % 2 == 0) ? 4'b0001 : 4'b0100);
      end

      // Lone requester is re-granted back to back
      cyc(1'b0, 4'h0, 4'h0);
      for (int c = 0; c < 12; c++) begin
         cyc(1'b1, 4'b1000, 4'h0);
         chk_gnt("single", 4'b1000);
      end

      // done from a non-owner is ignored; owner dropping req releases
      cyc(1'b0, 4'h0, 4'h0);
      cyc(1'b1, 4'b0010, 4'h0);    chk_gnt("own1", 4'b0010);
      cyc(1'b1, 4'b0010, 4'b0100); chk_gnt("ign_done", 4'b0010);
      cyc(1'b1, 4'b0000, 4'h0);    chk_gnt("req_drop", 4'b0000);
      cyc(1'b1, 4'b0000, 4'h0);    chk_gnt("idle", 4'b0000);

      // Reset in the middle of a grant
      cyc(1'b1, 4'b0100, 4'h0); chk_gnt("mid0", 4'b0100);
      cyc(1'b1, 4'b0100, 4'h0);
      cyc(1'b1, 4'b0100, 4'h0);
      cyc(1'b0, 4'b0100, 4'h0); chk_gnt("mid_reset", 4'b0000);
      cyc(1'b1, 4'b0100, 4'h0); chk_gnt("after_reset", 4'b0100);

      // Randomized traffic with occasional resets and stray done pulses
      r_rq = 4'hF;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) r_rq = 4'($urandom);
         cyc(($urandom_range(0, 199) != 0),
             r_rq,
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      end

      @(negedge clk);
      #1;
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
